// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer with branch, jump, call/return and stall.
// The return-address stack is built only when PC_SEQUENCER_RAS_EN is defined.
module pc_sequencer #(
  parameter int unsigned                PC_WIDTH     = 9,
  parameter int unsigned                OFFSET_WIDTH = 9,
  parameter logic [PC_WIDTH-1:0]        RESET_ADDR   = '0,
  parameter int unsigned                RAS_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall,
  input  logic                          take_branch,
  input  logic [OFFSET_WIDTH-1:0]       offset,
  input  logic                          jump,
  input  logic                          call,
  input  logic                          ret,
  input  logic [PC_WIDTH-1:0]           jump_target,
  output logic [PC_WIDTH-1:0]           pc,
  output logic [$clog2(RAS_DEPTH):0]    ras_count,
  output logic                          ras_overflow,
  output logic                          ras_underflow
);

  logic [PC_WIDTH-1:0] pc_next;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] offset_ext;

  assign pc_inc     = pc + 1'b1;
  assign offset_ext = PC_WIDTH'(signed'(offset));

`ifdef PC_SEQUENCER_RAS_EN
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    top_ptr;
  logic                ras_full;
  logic                ras_empty;
  logic                push;
  logic                pop;
  logic                underflow_set;

  assign top_ptr   = wr_ptr - 1'b1;
  assign ras_full  = (ras_count == CNT_W'(RAS_DEPTH));
  assign ras_empty = (ras_count == '0);

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    pc_next       = pc_inc;
    push          = 1'b0;
    pop           = 1'b0;
    underflow_set = 1'b0;
    if (stall) begin
      pc_next = pc;
    end else if (ret) begin
      if (!ras_empty) begin
        pc_next = ras_mem[top_ptr];
        pop     = 1'b1;
      end else begin
        underflow_set = 1'b1;
      end
    end else if (call) begin
      pc_next = jump_target;
      push    = 1'b1;
    end else if (jump) begin
      pc_next = jump_target;
    end else if (take_branch) begin
      pc_next = pc + offset_ext;
    end
  end

  // A push onto a full stack overwrites the oldest entry; count saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr        <= '0;
      ras_count     <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (ras_full) ras_overflow <= 1'b1;
        else          ras_count    <= ras_count + 1'b1;
      end else if (pop) begin
        wr_ptr    <= top_ptr;
        ras_count <= ras_count - 1'b1;
      end
      if (underflow_set) ras_underflow <= 1'b1;
    end
  end

  // NOTE: stack storage has no reset; entries are only read while ras_count covers them.
  always_ff @(posedge clk) begin
    if (push) ras_mem[wr_ptr] <= pc_inc;
  end
`else
  always_comb begin
    pc_next = pc_inc;
    if (stall) begin
      pc_next = pc;
    end else if (ret) begin
      pc_next = pc_inc;
    end else if (call || jump) begin
      pc_next = jump_target;
    end else if (take_branch) begin
      pc_next = pc + offset_ext;
    end
  end

  assign ras_count     = '0;
  assign ras_overflow  = 1'b0;
  assign ras_underflow = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= RESET_ADDR;
    else     pc <= pc_next;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random stimulus
// compared against a queue-based reference model (follows PC_SEQUENCER_RAS_EN).
module tb_pc_sequencer;

  localparam int          PW    = 9;
  localparam logic [8:0]  RADDR = 9'h010;
  localparam int          DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall, take_branch, jump, call, ret;
  logic [8:0] offset, jump_target;
  logic [8:0] pc;
  logic [2:0] ras_count;
  logic       ras_overflow, ras_underflow;

  int passed = 0;
  int total  = 0;

  // Reference model state
  logic [8:0] m_pc;
  logic [8:0] m_stack[$];
  logic       m_ovf, m_unf;

`ifdef PC_SEQUENCER_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  pc_sequencer #(
    .PC_WIDTH(PW), .OFFSET_WIDTH(9), .RESET_ADDR(RADDR), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .take_branch(take_branch),
    .offset(offset), .jump(jump), .call(call), .ret(ret),
    .jump_target(jump_target), .pc(pc), .ras_count(ras_count),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pc = RADDR;
    m_stack.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_step();
    if (stall) return;
    if (RAS_EN && ret) begin
      if (m_stack.size() > 0) m_pc = m_stack.pop_back();
      else begin m_pc = m_pc + 9'd1; m_unf = 1'b1; end
    end else if (ret) begin
      m_pc = m_pc + 9'd1;
    end else if (call) begin
      if (RAS_EN) begin
        if (m_stack.size() == DEPTH) begin
          void'(m_stack.pop_front());
          m_ovf = 1'b1;
        end
        m_stack.push_back(m_pc + 9'd1);
      end
      m_pc = jump_target;
    end else if (jump) begin
      m_pc = jump_target;
    end else if (take_branch) begin
      m_pc = m_pc + offset;
    end else begin
      m_pc = m_pc + 9'd1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"}, 32'(pc), 32'(m_pc));
    check({tag, ".cnt"}, 32'(ras_count), RAS_EN ? 32'(m_stack.size()) : 32'd0);
    check({tag, ".ovf"}, 32'(ras_overflow), 32'(RAS_EN & m_ovf));
    check({tag, ".unf"}, 32'(ras_underflow), 32'(RAS_EN & m_unf));
  endtask

  // Apply one cycle of control inputs, then compare just after the edge.
  task automatic step(input string tag, input logic s, input logic r, input logic c,
                      input logic j, input logic b, input logic [8:0] off,
                      input logic [8:0] tgt);
    stall = s; ret = r; call = c; jump = j; take_branch = b;
    offset = off; jump_target = tgt;
    @(posedge clk);
    model_step();
    #1;
    stall = 0; ret = 0; call = 0; jump = 0; take_branch = 0;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 0, 9'h0, 9'h0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    stall = 0; ret = 0; call = 0; jump = 0; take_branch = 0;
    offset = '0; jump_target = '0;
    rst = 1'b1;
    #3;
    model_reset();
    check_all("reset");
    check("reset.pc_lit", 32'(pc), 32'h010);
    @(negedge clk);
    rst = 1'b0;

    // Reset and stall
    idle("seq0"); check("seq0.lit", 32'(pc), 32'h011);
    idle("seq1");
    idle("seq2"); check("seq2.lit", 32'(pc), 32'h013);
    step("stall0", 1, 0, 0, 0, 0, 9'h0, 9'h0);
    step("stall1", 1, 0, 0, 0, 0, 9'h0, 9'h0); check("stall.lit", 32'(pc), 32'h013);

    // Branch with wrap-around in both directions
    step("jmp1fe", 0, 0, 0, 1, 0, 9'h0, 9'h1FE);
    step("br_p3", 0, 0, 0, 0, 1, 9'd3, 9'h0);   check("br_p3.lit", 32'(pc), 32'h001);
    step("br_m2", 0, 0, 0, 0, 1, 9'h1FE, 9'h0); check("br_m2.lit", 32'(pc), 32'h1FF);

    // Call / return
    step("jmp20", 0, 0, 0, 1, 0, 9'h0, 9'h020);
    step("call80", 0, 0, 1, 0, 0, 9'h0, 9'h080); check("call80.lit", 32'(pc), 32'h080);
    idle("cr_i0");
    idle("cr_i1");
    step("ret21", 0, 1, 0, 0, 0, 9'h0, 9'h0);
    if (RAS_EN) check("ret21.lit", 32'(pc), 32'h021);
    else        check("ret21.lit", 32'(pc), 32'h083);

    // Overflow then underflow from a clean stack
    do_reset("rst_ovf");
    for (int i = 0; i < 5; i++) begin
      step("ovf_jmp", 0, 0, 0, 1, 0, 9'h0, 9'(i * 16));
      step("ovf_call", 0, 0, 1, 0, 0, 9'h0, 9'(i * 16));
    end
    for (int i = 0; i < 5; i++) step("ovf_ret", 0, 1, 0, 0, 0, 9'h0, 9'h0);

    // Priority cases
    do_reset("rst_pri");
    step("pri_jmp54", 0, 0, 0, 1, 0, 9'h0, 9'h054);
    step("pri_call", 0, 0, 1, 0, 0, 9'h0, 9'h0A0);
    step("pri_s_r_c", 1, 1, 1, 0, 0, 9'h0, 9'h0F0);
    if (RAS_EN) step("pri_c_r", 0, 1, 1, 0, 0, 9'h0, 9'h0F0);
    step("pri_j_b", 0, 0, 0, 1, 1, 9'h005, 9'h133);
    check("pri_j_b.lit", 32'(pc), 32'h133);

    // Reset in the middle of a stacked sequence
    step("mid_call0", 0, 0, 1, 0, 0, 9'h0, 9'h040);
    step("mid_call1", 0, 0, 1, 0, 0, 9'h0, 9'h060);
    do_reset("rst_mid");
    idle("post_rst"); check("post_rst.lit", 32'(pc), 32'h011);

    // Random stimulus against the model
    for (int n = 0; n < 400; n++) begin
      logic s, r, c, j, b;
      s = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 4) == 0);
      c = ($urandom_range(0, 4) == 0);
      j = ($urandom_range(0, 9) == 0);
      b = ($urandom_range(0, 3) == 0);
      if (!RAS_EN && r) begin c = 0; j = 0; b = 0; end
      step("rand", s, r, c, j, b, 9'($urandom), 9'($urandom));
      if (n == 200) do_reset("rand_rst");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the fetch stage; next generation of the core's 9-bit PC. It adds configurable width, a fetch stall, absolute jumps, and call/return handling backed by a circular return-address stack (RAS). The instruction memory address is driven directly from `pc`. All control inputs are sampled on the rising clock edge.

## Interface
Parameters:
- `PC_WIDTH`, 9: width of `pc`, `jump_target` and RAS entries.
- `OFFSET_WIDTH`, 9: width of signed branch `offset`; must be ≤ `PC_WIDTH`.
- `RESET_ADDR`, 0: value loaded into `pc` on reset.
- `RAS_DEPTH`, 4: RAS entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hold `pc` and RAS unchanged.
- `take_branch`  in  1  PC-relative branch.
- `offset`  in  OFFSET_WIDTH  signed branch displacement, in instruction units.
- `jump`  in  1  absolute jump to `jump_target`.
- `call`  in  1  jump to `jump_target` and push `pc+1`.
- `ret`  in  1  pop the RAS into `pc`.
- `jump_target`  in  PC_WIDTH  absolute target for `jump` and `call`.
- `pc`  out  PC_WIDTH  current fetch address (registered).
- `ras_count`  out  $clog2(RAS_DEPTH)+1  number of valid RAS entries.
- `ras_overflow`  out  1  sticky; a push occurred when the RAS was full.
- `ras_underflow`  out  1  sticky; a `ret` occurred when the RAS was empty.

## Operation
- Next-PC priority, highest first: `stall` > `ret` > `call` > `jump` > `take_branch` > sequential `pc+1`.
- **stall**: `pc`, RAS contents, `ras_count` and the flags all hold. Every other input is ignored.
- **ret**, RAS non-empty: `pc` ← top entry; `ras_count` decrements.
- **ret**, RAS empty: `pc` ← `pc+1`; `ras_underflow` sets; `ras_count` stays 0.
- **call**: `pc` ← `jump_target`; `pc+1` is pushed.
  - If the RAS is not full, `ras_count` increments.
  - If the RAS is full, the oldest entry is overwritten (circular), `ras_count` stays at `RAS_DEPTH`, and `ras_overflow` sets.
- **jump**: `pc` ← `jump_target`. The RAS is untouched.
- **take_branch**: `pc` ← `pc + sign_extend(offset)`.
- **Arithmetic**: all additions are modulo 2^PC_WIDTH, with wrap-around and no flag. `offset` is sign-extended to `PC_WIDTH`. The pushed value `pc+1` also wraps.
- **Simultaneous call+ret**: `ret` wins. Exactly one pop occurs and no push.
- **RAS storage**: a write pointer and `ras_count`. Top entry = entry at (write pointer − 1) mod `RAS_DEPTH`.
- **Flags**: sticky until reset.

## Timing
- **Reset** (async assert, applies immediately):
  - `pc` = `RESET_ADDR`, `ras_count` = 0, `ras_overflow` = 0, `ras_underflow` = 0.
  - RAS pointer = 0. RAS entry contents are don't-care.
- **Reset deassert**: the first update occurs on the first rising edge with `rst` low.
- **Latency**: control inputs sampled at edge N are reflected on `pc` and the RAS outputs immediately after edge N. There is no combinational path from inputs to outputs.
- **Reset mid-operation**: pending stack contents are discarded; `ras_count` = 0.
- **Back-to-back**:
  - `call` followed by `ret` on consecutive cycles returns to the pushed address.
  - Any mix of push and pop is legal every cycle.

## Configuration
- `PC_SEQUENCER_RAS_EN` defined: the RAS and its flags are implemented as described above.
- Macro undefined:
  - No RAS storage is built.
  - `call` behaves exactly as `jump`.
  - `ret` is treated as sequential (`pc+1`).
  - `ras_count`, `ras_overflow` and `ras_underflow` are tied to 0.
  - Priority among the remaining inputs is unchanged.

## Test plan
- **Reset and stall**: `RESET_ADDR`=0x010, assert `rst`, release, 3 idle cycles → `pc` = 0x010, 0x011, 0x012, 0x013. Then `stall` for 2 cycles → `pc` holds 0x013.
- **Branch and wrap**: `pc`=0x1FE, `take_branch`, `offset`=+3 → `pc`=0x001. Then `offset`=−2 (9'h1FE) → `pc`=0x1FF.
- **Call/return**: at `pc`=0x020, `call` with target 0x080 → `pc`=0x080, `ras_count`=1. Two idles, then `ret` → `pc`=0x021, `ras_count`=0.
- **Overflow**: `RAS_DEPTH`=4, five consecutive calls from `pc` = 0x00,0x10,0x20,0x30,0x40 → `ras_overflow`=1, `ras_count`=4. Four rets → `pc` = 0x41, 0x31, 0x21, 0x11. A fifth ret → `pc` increments, `ras_underflow`=1.
- **Priority**: `stall`+`ret`+`call` together → no change. `call`+`ret` together with top=0x055 → `pc`=0x055, `ras_count` decrements. `jump`+`take_branch` → `pc`=`jump_target`.
- **Macro off**: `call` to 0x080 → `pc`=0x080, `ras_count`=0. `ret` → `pc`=0x081, and all flags stay 0.
